// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time toward a word-only data memory.
// Sub-word stores are done as read-modify-write; errors complete without a memory strobe.
module load_store_unit #(
   parameter int unsigned MEM_WORDS    = 32,
   parameter bit          CHECK_BOUNDS = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   // Handshake: a request transfers on a rising edge where req_valid && req_ready.
   // req_ready is high only in IDLE with reset released; resp_valid is a one-cycle pulse.
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [31:0] address,
   output logic [31:0] write_data,
   input  logic [31:0] read_data,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] word_q, word_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic [31:0] address_q, address_d;
   logic [31:0] write_data_q, write_data_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        req_err;

   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] f3);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (a)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b100:  r = {24'h0, b};
         3'b101:  r = {16'h0, h};
         default: r = w;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] a,
                                               input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] r;
      r = w;
      if (f3 == 3'b000) begin
         case (a)
            2'd0:    r[7:0]   = d[7:0];
            2'd1:    r[15:8]  = d[7:0];
            2'd2:    r[23:16] = d[7:0];
            default: r[31:24] = d[7:0];
         endcase
      end else if (a[1]) begin
         r[31:16] = d[15:0];
      end else begin
         r[15:0] = d[15:0];
      end
      return r;
   endfunction

   always_comb begin
      logic legal, misaligned, out_of_range;
      if (req_we)
         legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
      else
         legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                 (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
      misaligned = (((req_funct3 == 3'b001) || (req_funct3 == 3'b101)) && req_addr[0]) ||
                   ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
      out_of_range = CHECK_BOUNDS && ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
      req_err = !legal || misaligned || out_of_range;
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      we_d         = we_q;
      f3_d         = f3_q;
      wdata_d      = wdata_q;
      word_d       = word_q;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      address_d    = address_q;
      write_data_d = write_data_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = 32'h0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               we_d    = req_we;
               f3_d    = req_funct3;
               wdata_d = req_wdata;
               if (req_err) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (req_we && (req_funct3 == 3'b010)) begin
                  state_d      = WR;
                  mem_write_d  = 1'b1;
                  address_d    = {req_addr[31:2], 2'b00};
                  write_data_d = req_wdata;
               end else begin
                  // Loads and sub-word stores both start by reading the target word.
                  state_d    = RD;
                  mem_read_d = 1'b1;
                  address_d  = {req_addr[31:2], 2'b00};
               end
            end
         end
         RD: begin
            word_d = read_data;
            if (we_q) begin
               state_d      = WR;
               mem_write_d  = 1'b1;
               write_data_d = store_merge(read_data, addr_q[1:0], f3_q, wdata_q);
            end else begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_ext(read_data, addr_q[1:0], f3_q);
            end
         end
         WR: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         addr_q       <= 32'h0;
         we_q         <= 1'b0;
         f3_q         <= 3'b000;
         wdata_q      <= 32'h0;
         word_q       <= 32'h0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         address_q    <= 32'h0;
         write_data_q <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         f3_q         <= f3_d;
         wdata_q      <= wdata_d;
         word_q       <= word_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         address_q    <= address_d;
         write_data_q <= write_data_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign req_ready   = (state_q == IDLE) && rst;
   assign resp_valid  = resp_valid_q;
   assign resp_err    = resp_err_q;
   assign resp_rdata  = resp_rdata_q;
   assign MemRead     = mem_read_q;
   assign MemWrite    = mem_write_q;
   assign address     = address_q;
   assign write_data  = write_data_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 32-word behavioural data memory.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic [1:0]  dbg_state;

   logic [31:0] mem [0:31];
   logic        pre_we;
   logic [4:0]  pre_idx;
   logic [31:0] pre_data;

   int n_checks = 0;
   int n_fail   = 0;

   load_store_unit #(.MEM_WORDS(32), .CHECK_BOUNDS(1'b1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
      .write_data(write_data), .read_data(read_data), .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   // Memory: combinational read while MemRead, word write on the rising edge.
   assign read_data = MemRead ? mem[address[6:2]] : 32'h0;
   always @(posedge clk) begin
      if (MemWrite) mem[address[6:2]] <= write_data;
      else if (pre_we) mem[pre_idx] <= pre_data;
   end

   task automatic preload(input int idx, input logic [31:0] d);
      pre_idx  = 5'(idx);
      pre_data = d;
      pre_we   = 1'b1;
      @(posedge clk);
      #1 pre_we = 1'b0;
   endtask

   // Issues one request and reports latency (cycles after accept, -1 on timeout).
   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic err,
                          output logic [31:0] rdata, output int nrd, output int nwr,
                          output logic [31:0] last_wd);
      lat = -1; err = 1'b0; rdata = 32'hx; nrd = 0; nwr = 0; last_wd = 32'h0;
      for (int w = 0; w < 10 && !req_ready; w++) @(negedge clk);
      if (!req_ready) return;
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (MemRead) nrd++;
         if (MemWrite) begin
            nwr++;
            last_wd = write_data;
         end
         if (resp_valid) begin
            lat = c; err = resp_err; rdata = resp_rdata;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #3;
      n_checks++;
      if ({req_ready, resp_valid, resp_err, MemRead, MemWrite} !== 5'b0 ||
          resp_rdata !== 32'h0 || address !== 32'h0 || write_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs got rdy=%b rv=%b re=%b mr=%b mw=%b rd=%h a=%h wd=%h exp all 0",
                  req_ready, resp_valid, resp_err, MemRead, MemWrite, resp_rdata, address, write_data);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready got %b exp 1", req_ready);
      end
   endtask

   task automatic test_loads;
      logic [2:0]  f3s  [8] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
      logic [31:0] adrs [8] = '{32'h4, 32'h5, 32'h6, 32'h7, 32'h6, 32'h6, 32'h6, 32'h4};
      logic [31:0] exps [8] = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80,
                                32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};
      int lat, nrd, nwr;
      logic err;
      logic [31:0] rdata, lwd;
      preload(1, 32'h80FF_7F01);
      for (int i = 0; i < 8; i++) begin
         run_req(1'b0, f3s[i], adrs[i], 32'h0, lat, err, rdata, nrd, nwr, lwd);
         n_checks++;
         if (lat !== 2 || err !== 1'b0 || rdata !== exps[i] || nrd !== 1 || nwr !== 0) begin
            n_fail++;
            $display("FAIL load_%0d got lat=%0d err=%b rdata=%h rd=%0d wr=%0d exp lat=2 err=0 rdata=%h rd=1 wr=0",
                     i, lat, err, rdata, nrd, nwr, exps[i]);
         end
      end
   endtask

   task automatic test_subword_store;
      int lat, nrd, nwr;
      logic err;
      logic [31:0] rdata, lwd;
      preload(2, 32'h1122_3344);
      run_req(1'b1, 3'b000, 32'h9, 32'h0000_00AA, lat, err, rdata, nrd, nwr, lwd);
      n_checks++;
      if (lat !== 3 || err !== 1'b0 || rdata !== 32'h0 || nrd !== 1 || nwr !== 1 ||
          lwd !== 32'h1122_AA44) begin
         n_fail++;
         $display("FAIL sb got lat=%0d err=%b rdata=%h rd=%0d wr=%0d wd=%h exp lat=3 err=0 rdata=0 rd=1 wr=1 wd=1122aa44",
                  lat, err, rdata, nrd, nwr, lwd);
      end
      run_req(1'b1, 3'b001, 32'hA, 32'h0000_BEEF, lat, err, rdata, nrd, nwr, lwd);
      n_checks++;
      if (lat !== 3 || err !== 1'b0 || nrd !== 1 || nwr !== 1 || mem[2] !== 32'hBEEF_AA44) begin
         n_fail++;
         $display("FAIL sh got lat=%0d err=%b rd=%0d wr=%0d mem2=%h exp lat=3 err=0 rd=1 wr=1 mem2=beefaa44",
                  lat, err, nrd, nwr, mem[2]);
      end
      run_req(1'b1, 3'b010, 32'h10, 32'hCAFE_F00D, lat, err, rdata, nrd, nwr, lwd);
      n_checks++;
      if (lat !== 2 || err !== 1'b0 || rdata !== 32'h0 || nrd !== 0 || nwr !== 1 ||
          mem[4] !== 32'hCAFE_F00D) begin
         n_fail++;
         $display("FAIL sw got lat=%0d err=%b rdata=%h rd=%0d wr=%0d mem4=%h exp lat=2 err=0 rdata=0 rd=0 wr=1 mem4=cafef00d",
                  lat, err, rdata, nrd, nwr, mem[4]);
      end
   endtask

   task automatic test_errors;
      logic        wes  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [2:0]  f3s  [5] = '{3'b010, 3'b001, 3'b001, 3'b011, 3'b010};
      logic [31:0] adrs [5] = '{32'h2, 32'h3, 32'h1, 32'h0, 32'h80};
      int lat, nrd, nwr;
      logic err;
      logic [31:0] rdata, lwd;
      for (int i = 0; i < 5; i++) begin
         run_req(wes[i], f3s[i], adrs[i], 32'hFFFF_FFFF, lat, err, rdata, nrd, nwr, lwd);
         n_checks++;
         if (lat !== 1 || err !== 1'b1 || rdata !== 32'h0 || nrd !== 0 || nwr !== 0) begin
            n_fail++;
            $display("FAIL err_%0d got lat=%0d err=%b rdata=%h rd=%0d wr=%0d exp lat=1 err=1 rdata=0 rd=0 wr=0",
                     i, lat, err, rdata, nrd, nwr);
         end
      end
      n_checks++;
      if (mem[0] !== 32'h0 || mem[1] !== 32'h80FF_7F01) begin
         n_fail++;
         $display("FAIL err_mem_untouched got mem0=%h mem1=%h exp 0 80ff7f01", mem[0], mem[1]);
      end
   endtask

   task automatic test_back_to_back;
      int acc [4];
      int idx = 0;
      int bad_ready = 0;
      for (int i = 0; i < 4; i++) preload(i, 32'h0);
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'hA0A0_0000;
      req_valid = 1'b1;
      for (int c = 0; c < 16; c++) begin
         if (c > 0) @(negedge clk);
         if (req_ready && (MemWrite || resp_valid)) bad_ready++;
         if (req_ready && req_valid && idx < 4) begin
            acc[idx] = c;
            @(posedge clk);
            #1;
            idx++;
            req_addr  = 32'(idx * 4);
            req_wdata = 32'hA0A0_0000 + 32'(idx);
            if (idx == 4) req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      n_checks++;
      if (idx !== 4 || acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3 || acc[3] - acc[2] !== 3) begin
         n_fail++;
         $display("FAIL b2b_accepts got n=%0d at %0d %0d %0d %0d exp 4 accepts 3 cycles apart",
                  idx, acc[0], acc[1], acc[2], acc[3]);
      end
      n_checks++;
      if (bad_ready !== 0) begin
         n_fail++;
         $display("FAIL b2b_ready_busy got %0d cycles ready during WR/RESP exp 0", bad_ready);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (mem[i] !== 32'hA0A0_0000 + 32'(i)) begin
            n_fail++;
            $display("FAIL b2b_mem_%0d got %h exp %h", i, mem[i], 32'hA0A0_0000 + 32'(i));
         end
      end
   endtask

   task automatic test_reset_abort;
      int lat, nrd, nwr, wr_seen;
      logic err;
      logic [31:0] rdata, lwd;
      preload(3, 32'h1234_5678);
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'hD; req_wdata = 32'h55;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n_checks++;
      if (MemRead !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_in_rd got MemRead=%b exp 1", MemRead);
      end
      #1 rst = 1'b0;
      #1;
      n_checks++;
      if ({req_ready, resp_valid, resp_err, MemRead, MemWrite} !== 5'b0 ||
          resp_rdata !== 32'h0 || address !== 32'h0 || write_data !== 32'h0) begin
         n_fail++;
         $display("FAIL abort_outputs got rdy=%b rv=%b re=%b mr=%b mw=%b rd=%h a=%h wd=%h exp all 0",
                  req_ready, resp_valid, resp_err, MemRead, MemWrite, resp_rdata, address, write_data);
      end
      wr_seen = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (MemWrite || resp_valid) wr_seen++;
      end
      rst = 1'b1;
      @(negedge clk);
      if (MemWrite || resp_valid) wr_seen++;
      n_checks++;
      if (wr_seen !== 0 || mem[3] !== 32'h1234_5678 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_no_write got strobes=%0d mem3=%h ready=%b exp 0 12345678 1",
                  wr_seen, mem[3], req_ready);
      end
      run_req(1'b0, 3'b010, 32'hC, 32'h0, lat, err, rdata, nrd, nwr, lwd);
      n_checks++;
      if (lat !== 2 || err !== 1'b0 || rdata !== 32'h1234_5678 || nrd !== 1 || nwr !== 0) begin
         n_fail++;
         $display("FAIL abort_then_lw got lat=%0d err=%b rdata=%h rd=%0d wr=%0d exp lat=2 err=0 rdata=12345678 rd=1 wr=0",
                  lat, err, rdata, nrd, nwr);
      end
   endtask

   initial begin
      rst = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0;
      pre_we = 1'b0; pre_idx = 5'd0; pre_data = 32'h0;
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      test_reset();
      test_loads();
      test_subword_store();
      test_errors();
      test_back_to_back();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the word-addressed data memory port. Takes one load/store request at a time from the execute stage and drives `MemRead`, `MemWrite`, `address` and `write_data` toward the data memory.
- Returns sign- or zero-extended load data to the pipeline.
- Implements byte and halfword stores as read-modify-write, because the memory only writes whole words.
- Flags misaligned, out-of-range and illegal accesses without touching memory.

Parameters:
- MEM_WORDS, 32, number of 32-bit words in the data memory; word index must be < MEM_WORDS.
- CHECK_BOUNDS, 1, when 1 an out-of-range word index raises resp_err; when 0 the index is passed through unchecked.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  one clock; reset is asynchronous and active-low.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle and able to accept; transfer occurs when req_valid && req_ready at a rising edge.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle pulse: request complete.
- resp_err  output  1  valid with resp_valid: misaligned, illegal funct3 or out of range.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write enable, sampled by memory at rising edge.
- address  output  32  word-aligned byte address {addr_q[31:2],2'b00}.
- write_data  output  32  full word to write.
- read_data  input  32  memory read word, combinational from address while MemRead=1.

Behaviour:
- States: IDLE, RD, WR, RESP. Request fields are latched on acceptance (addr_q, we_q, f3_q, wdata_q).
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - resp_valid=0, resp_err=0, resp_rdata=0, MemRead=0, MemWrite=0, address=0, write_data=0.
  - req_ready=0 while rst=0; req_ready=1 from the first cycle after release.
- req_ready = (state==IDLE) && rst. Requests are never accepted in any other state.
- Error check at acceptance; any error goes IDLE->RESP with resp_err=1, resp_rdata=0, and no memory strobe. Error conditions:
  - funct3 not in the legal set for the direction. Stores allow only 000/001/010; loads allow 000/001/010/100/101.
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=00.
  - CHECK_BOUNDS=1 and addr[31:2] >= MEM_WORDS.
- Transitions without error:
  - load: IDLE->RD->RESP->IDLE.
  - SW: IDLE->WR->RESP->IDLE.
  - SB/SH: IDLE->RD->WR->RESP->IDLE.
- RD: MemRead=1, address valid. At the rising edge, read_data is captured into word_q. This is exactly one RD cycle; no wait states.
- WR: MemWrite=1 for exactly one cycle. write_data is:
  - SW: wdata_q.
  - SB: word_q with byte lane addr_q[1:0] replaced by wdata_q[7:0].
  - SH: word_q with half lane addr_q[1] replaced by wdata_q[15:0].
- RESP: resp_valid=1 for one cycle.
  - Loads: resp_rdata = lane of word_q selected by addr_q[1:0], sign-extended (B/H) or zero-extended (BU/HU); W returns the full word.
  - Stores: resp_rdata=0.
- MemRead and MemWrite are never high together and are 0 in IDLE and RESP.
- Latency from the accept edge to resp_valid high:
  - loads and SW: 1 cycle after the RD/WR cycle, i.e. resp_valid during the 2nd cycle.
  - SB/SH: 3rd cycle.
  - errors: 1st cycle.
- Back-to-back: the next request can be accepted in the cycle after RESP. There is no accept during RESP.
- Reset asserted mid-operation aborts immediately. If asserted before the WR rising edge, no write is issued. No resp_valid is produced for the aborted request.
- Memory strobes and address/write_data are registered outputs decoded from state, so they are glitch-free relative to clk.

Test Plan:
- Preload mem[1]=0x80FF_7F01. LB at addr 0x4, 0x5, 0x6, 0x7 -> resp_rdata 0x0000_0001, 0x0000_007F, 0xFFFF_FFFF, 0xFFFF_FF80. LBU at 0x6 -> 0x0000_00FF.
- Same word: LH at 0x6 -> 0xFFFF_80FF; LHU at 0x6 -> 0x0000_80FF; LW at 0x4 -> 0x80FF_7F01. Each has resp_valid in the 2nd cycle after accept.
- mem[2]=0x1122_3344. SB 0xAA to 0x9 -> one MemRead cycle, then one MemWrite cycle with write_data 0x1122_AA44. Then SH 0xBEEF to 0xA -> mem[2]=0xBEEF_AA44.
- LW at 0x2, LH at 0x3, SH at 0x1, funct3=011 load, LW at 0x80 (MEM_WORDS=32) -> each gives resp_err=1 on the 1st cycle, and MemRead/MemWrite never asserted.
- Hold req_valid high with 4 back-to-back SW to 0x0, 0x4, 0x8, 0xC -> req_ready low during WR/RESP, accepts every 3 cycles, and the memory contents match in order.
- Drop rst during the RD cycle of an SB -> all outputs 0 immediately, no MemWrite, target word unchanged. After release, req_ready=1 and a new LW completes normally.
